// File: rtl/jbi_min_rq_rdq_rd_ctl_pkg.sv
// Shared widths and helpers for the RDQ read-side drain controller.
// Widths follow the JBI defaults for the RDQ payload and address.
package jbi_min_rq_rdq_rd_ctl_pkg;

  localparam int RDQ_W = 156;

  localparam int RDQ_AW = 4;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  // Room for one more read when queued plus in-flight stays under depth.
  function automatic logic skid_room(
    input skid_cnt_t cnt,
    input logic      inflight
  );
    return ({1'b0, cnt} + {2'b00, inflight}) < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/jbi_min_rq_rdq_skid.sv
// Two-entry skid queue catching RDQ read data ahead of the consumer.
// Head/tail are a single toggle bit; tail is head offset by cnt.
module jbi_min_rq_rdq_skid
  import jbi_min_rq_rdq_rd_ctl_pkg::*;
#(
  parameter int DATA_W = RDQ_W
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output skid_cnt_t         cnt,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [SKID_DEPTH];
  logic              hd;
  logic              tl;

  assign tl   = hd ^ cnt[0];
  assign head = mem[hd];

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      mem[0] <= '0;
      mem[1] <= '0;
      hd     <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push)
        mem[tl] <= push_data;
      if (pop)
        hd <= ~hd;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/jbi_min_rq_rdq_rd_ctl.sv
// RDQ read-side drain controller: pointer compare, read issue, skid output.
// Define JBI_RDQ_RD_PERF_EN to add the saturating pop counter perf_cnt.
module jbi_min_rq_rdq_rd_ctl
  import jbi_min_rq_rdq_rd_ctl_pkg::*;
#(
  parameter int DATA_W = RDQ_W,
  parameter int ADDR_W = RDQ_AW
) (
  input  logic              clk,
  input  logic              arst_l,
  input  logic [ADDR_W:0]   wptr,
  output logic              rdq_rd_en,
  output logic [ADDR_W-1:0] rdq_raddr,
  input  logic [DATA_W-1:0] rdq_rdata,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_rdy,
  output logic [ADDR_W:0]   rptr,
  output logic              rdq_empty
`ifdef JBI_RDQ_RD_PERF_EN
  ,
  output logic [15:0]       perf_cnt
`endif
);

  logic      rst_done;
  logic      inflight;
  logic      pop;
  logic      issue;
  skid_cnt_t cnt;

  assign rdq_empty = (wptr == rptr);
  assign rdq_raddr = rptr[ADDR_W-1:0];
  assign out_vld   = (cnt != '0);
  assign pop       = out_vld & out_rdy;
  assign issue     = rst_done & ~rdq_empty
                   & (skid_room(cnt, inflight) | pop);
  assign rdq_rd_en = issue;

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      rst_done <= 1'b0;
      inflight <= 1'b0;
      rptr     <= '0;
    end else begin
      rst_done <= 1'b1;
      inflight <= issue;
      if (issue)
        rptr <= rptr + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  jbi_min_rq_rdq_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .arst_l    (arst_l),
    .push      (inflight),
    .push_data (rdq_rdata),
    .pop       (pop),
    .cnt       (cnt),
    .head      (out_data)
  );

`ifdef JBI_RDQ_RD_PERF_EN
  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l)
      perf_cnt <= '0;
    else if (pop && perf_cnt != 16'hFFFF)
      perf_cnt <= perf_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_jbi_min_rq_rdq_rd_ctl.sv
// Bench for jbi_min_rq_rdq_rd_ctl: directed cases plus random traffic.
// Reference is an in-order FIFO of written payloads and a RAM model.
module tb_jbi_min_rq_rdq_rd_ctl;
  import jbi_min_rq_rdq_rd_ctl_pkg::*;

  localparam int DW = RDQ_W;
  localparam int AW = RDQ_AW;

  logic          clk = 1'b0;
  logic          arst_l;
  logic [AW:0]   wptr;
  logic          rdq_rd_en;
  logic [AW-1:0] rdq_raddr;
  logic [DW-1:0] rdq_rdata;
  logic          out_vld;
  logic [DW-1:0] out_data;
  logic          out_rdy;
  logic [AW:0]   rptr;
  logic          rdq_empty;
`ifdef JBI_RDQ_RD_PERF_EN
  logic [15:0]   perf_cnt;
`endif

  always #5 clk = ~clk;

  jbi_min_rq_rdq_rd_ctl #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .arst_l    (arst_l),
    .wptr      (wptr),
    .rdq_rd_en (rdq_rd_en),
    .rdq_raddr (rdq_raddr),
    .rdq_rdata (rdq_rdata),
    .out_vld   (out_vld),
    .out_data  (out_data),
    .out_rdy   (out_rdy),
    .rptr      (rptr),
    .rdq_empty (rdq_empty)
`ifdef JBI_RDQ_RD_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] exp_q [$];
  int            raddr_q [$];
  int            checks = 0;
  int            errors = 0;
  int            issues = 0;
  int            pops = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk)
    if (rdq_rd_en)
      rdq_rdata <= mem[rdq_raddr];

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Consumer-side scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!arst_l) begin
      prev_hold = 1'b0;
    end else begin
      if (rdq_rd_en) begin
        issues++;
        raddr_q.push_back(int'(rdq_raddr));
        chk("rd_nonempty", DW'(wptr == rptr), '0);
      end
      if (prev_hold) begin
        chk("hold_vld", DW'(out_vld), DW'(1));
        chk("hold_data", out_data, prev_data);
      end
      if (out_vld && out_rdy) begin
        pops++;
        if (exp_q.size() == 0)
          chk("pop_spurious", DW'(1), '0);
        else
          chk("pop_data", out_data, exp_q.pop_front());
      end
      prev_hold = out_vld && !out_rdy;
      prev_data = out_data;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_n(input int n);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = '0;
      for (int b = 0; b < DW; b += 32)
        d = (d << 32) | DW'($urandom);
      mem[wptr[AW-1:0]] = d;
      exp_q.push_back(d);
      wptr = wptr + {{AW{1'b0}}, 1'b1};
    end
  endtask

  task automatic reset_assert();
    arst_l  = 1'b0;
    wptr    = '0;
    out_rdy = 1'b0;
    exp_q.delete();
    raddr_q.delete();
    issues = 0;
    pops   = 0;
  endtask

  task automatic reset_checks();
    chk("rst_vld", DW'(out_vld), '0);
    chk("rst_data", out_data, '0);
    chk("rst_rptr", DW'(rptr), '0);
    chk("rst_rden", DW'(rdq_rd_en), '0);
`ifdef JBI_RDQ_RD_PERF_EN
    chk("rst_perf", DW'(perf_cnt), '0);
`endif
  endtask

  task automatic drain(input int budget);
    int left = budget;
    out_rdy = 1'b1;
    while (exp_q.size() != 0 && left > 0) begin
      tick();
      left--;
    end
    chk("drain_left", DW'(exp_q.size()), '0);
  endtask

  logic [AW:0] used;
  int          space;
  int          n;

  initial begin
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = '0;
    rdq_rdata = '0;
    reset_assert();

    // Idle after reset with an empty buffer
    #2;
    reset_checks();
    chk("rst_empty", DW'(rdq_empty), DW'(1));
    tick(2);
    arst_l = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rden", DW'(rdq_rd_en), '0);
      chk("idle_vld", DW'(out_vld), '0);
    end
    chk("idle_rptr", DW'(rptr), '0);
    chk("idle_empty", DW'(rdq_empty), DW'(1));

    // Entry present across reset release
    reset_assert();
    write_n(1);
    tick(2);
    arst_l = 1'b1;
    chk("first_rden", DW'(rdq_rd_en), '0);
    tick();
    chk("second_rden", DW'(rdq_rd_en), DW'(1));
    chk("second_raddr", DW'(rdq_raddr), '0);
    tick();
    chk("lat_vld1", DW'(out_vld), '0);
    chk("lat_rptr", DW'(rptr), DW'(1));
    tick();
    chk("lat_vld2", DW'(out_vld), DW'(1));
    chk("lat_data", out_data, exp_q[0]);
    out_rdy = 1'b1;
    tick();
    chk("lat_popped", DW'(pops), DW'(1));

    // Full-buffer burst at one entry per clock
    reset_assert();
    tick();
    arst_l = 1'b1;
    tick();
    out_rdy = 1'b1;
    write_n(16);
    tick(17);
    chk("burst_pops17", DW'(pops), DW'(15));
    tick();
    chk("burst_pops18", DW'(pops), DW'(16));
    chk("burst_issues", DW'(issues), DW'(16));
    for (int i = 0; i < 16; i++)
      chk("burst_raddr", DW'(raddr_q[i]), DW'(i));
    chk("burst_rptr", DW'(rptr), DW'(16));
    chk("burst_empty", DW'(rdq_empty), DW'(1));

    // Back-pressure: only two reads outstanding
    reset_assert();
    tick();
    arst_l = 1'b1;
    tick();
    write_n(5);
    tick(8);
    chk("bp_issues", DW'(issues), DW'(2));
    chk("bp_rptr", DW'(rptr), DW'(2));
    chk("bp_vld", DW'(out_vld), DW'(1));
    chk("bp_pops", DW'(pops), '0);
    out_rdy = 1'b1;
    tick(12);
    chk("bp_drained", DW'(pops), DW'(5));
    chk("bp_left", DW'(exp_q.size()), '0);
    chk("bp_rptr_end", DW'(rptr), DW'(5));

    // Pointer wrap from 30 to 2
    reset_assert();
    tick();
    arst_l = 1'b1;
    tick();
    out_rdy = 1'b1;
    write_n(16);
    tick(20);
    write_n(14);
    tick(20);
    chk("wrap_rptr30", DW'(rptr), DW'(30));
    raddr_q.delete();
    write_n(4);
    chk("wrap_wptr", DW'(wptr), DW'(2));
    tick(10);
    chk("wrap_n", DW'(raddr_q.size()), DW'(4));
    if (raddr_q.size() == 4) begin
      chk("wrap_a0", DW'(raddr_q[0]), DW'(14));
      chk("wrap_a1", DW'(raddr_q[1]), DW'(15));
      chk("wrap_a2", DW'(raddr_q[2]), DW'(0));
      chk("wrap_a3", DW'(raddr_q[3]), DW'(1));
    end
    chk("wrap_rptr", DW'(rptr), DW'(2));
    chk("wrap_empty", DW'(rdq_empty), DW'(1));
`ifdef JBI_RDQ_RD_PERF_EN
    chk("perf_cnt", DW'(perf_cnt), DW'(pops));
`endif

    // Reset while a read is in flight
    out_rdy = 1'b0;
    write_n(5);
    tick(2);
    #2;
    arst_l = 1'b0;
    #1;
    reset_checks();
    reset_assert();
    tick(2);
    arst_l = 1'b1;
    tick(5);
    chk("mid_vld", DW'(out_vld), '0);
    chk("mid_issues", DW'(issues), '0);
    chk("mid_rptr", DW'(rptr), '0);

    // Random producer and consumer traffic
    for (int c = 0; c < 3000; c++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        used  = wptr - rptr;
        space = 16 - int'(used);
        n     = $urandom_range(0, 3);
        if (n > space)
          n = space;
        write_n(n);
      end
      tick();
    end
    drain(100);
    tick(3);
    chk("rand_rptr", DW'(rptr), DW'(wptr));
    chk("rand_empty", DW'(rdq_empty), DW'(1));
    chk("rand_issues", DW'(issues), DW'(pops));
`ifdef JBI_RDQ_RD_PERF_EN
    chk("rand_perf", DW'(perf_cnt), DW'(pops));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
